// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider with a run/drain controller.
//
// Purpose: divides i_clk down to o_out. Each high and low phase lasts
// r_half i_clk cycles. A new half-period can be handed over at any time
// through a valid/ready port. While the divider runs, the new value is
// applied only at a rising edge of o_out, so a phase that has already
// started is never cut short.
//
// Optional feature: define CLK_DIV_CTRL_LOCK_EN to add the i_lock input.
// While i_lock=1, no configuration transfer is accepted. A value that is
// already pending still loads normally.
//
// Ports:
//   i_clk        system clock (rising edge)
//   i_reset      asynchronous reset, active low
//   i_en         run request (1 = run, 0 = stop after the high phase)
//   i_cfg_valid  new half-period offered
//   i_cfg_half   requested half-period in i_clk cycles (0/1 clamp to 2)
//   o_cfg_ready  a new half-period can be accepted
//   o_out        divided clock, registered
//   o_tick       one-cycle pulse in the cycle after o_out rises
//   o_busy       controller is in RUN or DRAIN
//   i_lock       (CLK_DIV_CTRL_LOCK_EN only) blocks configuration transfers
//
// state   | meaning
// S_IDLE  | stopped, o_out=0, counter held at 0
// S_RUN   | dividing, counter advances every cycle
// S_DRAIN | stop requested while high; finishing the high phase
module clk_div_ctrl #(
  parameter int unsigned system_freq   = 100_000_000,
  parameter int unsigned required_freq = 50_000,
  parameter int unsigned DIV_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
`ifdef CLK_DIV_CTRL_LOCK_EN
  input  logic             i_lock,
`endif
  input  logic             i_en,
  input  logic             i_cfg_valid,
  input  logic [DIV_W-1:0] i_cfg_half,
  output logic             o_cfg_ready,
  output logic             o_out,
  output logic             o_tick,
  output logic             o_busy
);

  localparam int unsigned      HALF0_FULL  = system_freq / (2 * required_freq);
  localparam logic [DIV_W-1:0] HALF0_TRUNC = DIV_W'(HALF0_FULL);
  // Apply the same 2-cycle minimum to the reset value, so that no
  // parameter set can produce a 1-cycle phase.
  localparam logic [DIV_W-1:0] HALF0       = (HALF0_TRUNC < DIV_W'(2)) ? DIV_W'(2) : HALF0_TRUNC;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
  logic [DIV_W-1:0] r_half;
  logic [DIV_W-1:0] r_pend_val;
  logic             r_pend;
  logic             r_out, w_out_nxt;
  logic             r_tick;

  logic             w_term;
  logic             w_rise;
  logic             w_load;
  logic             w_ready;
  logic             w_xfer;
  logic [DIV_W-1:0] w_cfg_clamped;

  assign w_term = (r_cnt == (r_half - DIV_W'(1)));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_out_nxt = 1'b0;
        if (i_en) w_state_nxt = S_RUN;
      end
      S_RUN, S_DRAIN: begin
        if ((r_state == S_RUN) && !i_en && !r_out) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          if (w_term) begin
            w_cnt_nxt = '0;
            w_out_nxt = ~r_out;
          end else begin
            w_cnt_nxt = r_cnt + DIV_W'(1);
          end
          // When en is low, o_out is high here. A terminal count means the
          // high phase just ended, so the controller stops on this edge.
          if (!i_en && w_term)  w_state_nxt = S_IDLE;
          else if (!i_en)       w_state_nxt = S_DRAIN;
          else                  w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_out_nxt   = 1'b0;
      end
    endcase
  end

  assign w_rise = w_out_nxt & ~r_out;
  // While running, load only at a rising edge, so that whole periods
  // use a single half-period value.
  assign w_load = r_pend && ((r_state == S_IDLE) || w_rise);

`ifdef CLK_DIV_CTRL_LOCK_EN
  assign w_ready = ~r_pend & ~i_lock;
`else
  assign w_ready = ~r_pend;
`endif
  assign w_xfer        = i_cfg_valid & w_ready;
  assign w_cfg_clamped = (i_cfg_half < DIV_W'(2)) ? DIV_W'(2) : i_cfg_half;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_half     <= HALF0;
      r_pend_val <= HALF0;
      r_pend     <= 1'b0;
      r_out      <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_tick  <= w_rise;
      if (w_load) r_half <= r_pend_val;
      // A transfer on the same edge as a load: the load has already taken
      // the old value, and the new value keeps pending set.
      if (w_xfer) begin
        r_pend_val <= w_cfg_clamped;
        r_pend     <= 1'b1;
      end else if (w_load) begin
        r_pend     <= 1'b0;
      end
    end
  end

  assign o_cfg_ready = w_ready;
  assign o_out       = r_out;
  assign o_tick      = r_tick;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter: system_freq, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter: required_freq, default 50_000, output frequency after reset in Hz.
REQ-003 Parameter: DIV_W, default 16, width of the half-period register.
REQ-004 Port: clk  input  1  system clock; the only clock; all logic on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: en  input  1  run request; 1 runs the divider, 0 stops it.
REQ-007 Port: cfg_valid  input  1  new half-period offered.
REQ-008 Port: cfg_half  input  DIV_W  requested half-period, in clk cycles.
REQ-009 Port: cfg_ready  output  1  controller can accept a new half-period.
REQ-010 Port: out  output  1  divided clock, registered.
REQ-011 Port: tick  output  1  one-cycle pulse in the cycle where out rises.
REQ-012 Port: busy  output  1  high when the state is RUN or DRAIN.

Function
REQ-013 The reset half-period SHALL be HALF0 = system_freq/(2*required_freq), which is 1000 with the default parameters; the result SHALL be truncated to DIV_W bits.
REQ-014 The block SHALL have three states:
- IDLE: out=0, cnt=0.
- RUN: cnt increments every cycle.
- DRAIN: RUN continues until the high half finishes.
REQ-015 IDLE SHALL move to RUN on the edge where en=1 is sampled; cnt SHALL start at 0.
REQ-016 In RUN or DRAIN, when cnt==half-1, the block SHALL toggle out and clear cnt to 0 on the same edge; otherwise cnt SHALL increment by 1.
REQ-017 tick SHALL be 1 exactly in the cycles where out has just changed from 0 to 1.
REQ-018 If en=0 is sampled in RUN with out=0, the block SHALL go to IDLE on that edge and clear cnt.
REQ-019 If en=0 is sampled in RUN with out=1, the block SHALL go to DRAIN.
REQ-020 DRAIN SHALL go to IDLE on the edge where out falls.
REQ-021 If en=1 is sampled in DRAIN, the block SHALL return to RUN without disturbing cnt or out.
REQ-022 cfg_ready SHALL be 1 when no update is pending.
REQ-023 A transfer SHALL occur when cfg_valid and cfg_ready are both 1 on a clock edge.
REQ-024 A transfer SHALL store cfg_half in the pending register and set pending, which drops cfg_ready on the next cycle.
REQ-025 A stored value of 0 or 1 SHALL be clamped to 2.
REQ-026 In IDLE, a pending value SHALL be loaded into half on the following edge and pending SHALL clear.
REQ-027 In RUN or DRAIN, a pending value SHALL load only on the edge where out toggles from 0 to 1, so every high and low half already started completes at the old half-period.
REQ-028 If a transfer and a load fall on the same edge, the load SHALL use the old pending value.
- The new value SHALL become pending.
- pending SHALL stay set.
REQ-029 If en is deasserted while an update is pending, the pending value SHALL load in IDLE.
REQ-030 out SHALL never produce a high or low phase shorter than 2 clk cycles.

Reset
REQ-031 Asserting reset (reset=0) SHALL asynchronously force:
- state=IDLE, cnt=0, half=HALF0;
- pending=0;
- out=0, tick=0, busy=0, cfg_ready=1.
REQ-032 Reset asserted in the middle of a period SHALL discard the period and any pending update.
REQ-033 Reset release SHALL be sampled on clk; the first state change SHALL occur no earlier than the first edge with reset=1.

Configuration
REQ-034 Macro CLK_DIV_CTRL_LOCK_EN, when defined, SHALL add the port lock (input, 1 bit).
- While lock=1: cfg_ready SHALL be 0 and no transfer SHALL occur.
- A pending update SHALL still load normally.
REQ-035 When CLK_DIV_CTRL_LOCK_EN is not defined, the lock port SHALL not exist and cfg_ready SHALL follow REQ-022 only.

Verification
REQ-036 Run at default parameters:
- Stimulus: release reset, then hold en=1.
- Response: out rises 1000 cycles after RUN entry, period 2000 cycles, tick one cycle per rise, busy=1.
REQ-037 Mid-period update:
- Stimulus: at cnt=300 of a low half, transfer cfg_half=5.
- Response: that low half stays 1000 cycles; the high half that follows is 5 cycles; cfg_ready=0 until the load, then 1.
REQ-038 Clamp:
- Stimulus: in IDLE, transfer cfg_half=0, then set en=1.
- Response: half=2; out toggles every 2 cycles; tick every 4 cycles.
REQ-039 Stop while high:
- Stimulus: set en=0 at cnt=10 of a high half with half=1000.
- Response: DRAIN; out falls 990 cycles later; IDLE; busy=0; out stays 0.
REQ-040 Reset mid-operation:
- Stimulus: reset=0 mid-high-phase with an update pending.
- Response: out=0, pending=0, half=1000, cfg_ready=1 immediately, without waiting for a clk edge.
REQ-041 With CLK_DIV_CTRL_LOCK_EN:
- Stimulus: lock=1 while cfg_valid=1 for 50 cycles.
- Response: no transfer; cfg_ready=0; half unchanged.
- Stimulus: release lock.
- Response: transfer on the next edge.
